// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and limits for the toggle-handshake CDC blocks.
//   cdc_state_e     - source-side FSM states (FLUSH, IDLE, WAIT_ACK)
//   MIN/MAX_SYNC_STAGES - legal synchronizer depth range
package cdc_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_state_e;

endpackage

// File: rtl/cdc_handshake_tx_sync.sv
// cdc_handshake_tx_sync: plain flip-flop chain synchronizer, no reset.
//   clk - destination (local) clock
//   d   - asynchronous input
//   q   - synchronized output, STAGES clocks of latency
module cdc_handshake_tx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // No reset: the owner drains stale contents with its own flush phase.
  always_ff @(posedge clk)
    sync_ff <= {sync_ff[STAGES-2:0], d};

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source half of a 2-phase (toggle) req/ack CDC handshake.
// A word accepted on in_valid/in_ready is held on tx_data while tx_req
// toggles; the next word is taken only once the synchronized tx_ack
// toggle matches tx_req.
//   clk, rst          - source clock, async active-high reset
//   in_valid/in_ready/in_data - upstream word interface
//   tx_data, tx_req   - word and request toggle to the destination domain
//   tx_ack            - acknowledge toggle from the destination (async)
//   busy              - transfer outstanding
// Optional: define CDC_HANDSHAKE_TX_TIMEOUT_EN to add TIMEOUT_CYCLES and a
// sticky timeout_err output flagging an ack that never arrives.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             busy
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("cdc_handshake_tx: SYNC_STAGES out of range");
  end

  localparam int FC_W = $clog2(MAX_SYNC_STAGES + 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(SYNC_STAGES - 1);

  cdc_state_e      state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            tx_req_nxt;
  logic            accept;
  logic            ready_st;
  logic            ack_sync;

  cdc_handshake_tx_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .d   (tx_ack),
    .q   (ack_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      tx_req    <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      tx_req    <= tx_req_nxt;
      if (accept) tx_data <= in_data;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    tx_req_nxt    = tx_req;
    accept        = 1'b0;
    ready_st      = 1'b0;
    unique case (state)
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          // Adopt the destination's current ack parity so a destination
          // that was not reset along with us does not see a phantom req.
          tx_req_nxt    = ack_sync;
          flush_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt + FC_W'(1);
        end
      end
      IDLE: begin
        ready_st = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          tx_req_nxt = ~tx_req;
          state_nxt  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == tx_req) state_nxt = IDLE;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  // Decoded from state only; rst gates it so it drops with the reset edge.
  assign in_ready = ready_st & ~rst;
  assign busy     = (state == WAIT_ACK);

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  // Counter saturates at TIMEOUT_CYCLES; the flag rises on the same edge
  // the count gets there and sticks until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == WAIT_ACK && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_MAX - TO_W'(1)) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       busy;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  logic       timeout_err;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_req = 1'b0;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .WIDTH       (8),
    .SYNC_STAGES (2)
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .busy     (busy)
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transfer from IDLE: in_valid stays high with the same word while
  // waiting, ack toggled dly cycles after acceptance, ready back 3 cycles later.
  task automatic xfer(input logic [7:0] w, input int dly);
    in_valid = 1'b1;
    in_data  = w;
    chk("x_ready_pre", {31'd0, in_ready}, 1);
    tick();
    exp_req = ~exp_req;
    chk("x_data", {24'd0, tx_data}, {24'd0, w});
    chk("x_req", {31'd0, tx_req}, {31'd0, exp_req});
    chk("x_busy", {31'd0, busy}, 1);
    chk("x_ready_busy", {31'd0, in_ready}, 0);
    repeat (dly) begin
      tick();
      chk("x_hold_data", {24'd0, tx_data}, {24'd0, w});
      chk("x_hold_ready", {31'd0, in_ready}, 0);
    end
    tx_ack = exp_req;
    repeat (2) begin
      tick();
      chk("x_sync_ready", {31'd0, in_ready}, 0);
      chk("x_sync_busy", {31'd0, busy}, 1);
    end
    tick();
    chk("x_ready_back", {31'd0, in_ready}, 1);
    chk("x_busy_clr", {31'd0, busy}, 0);
    chk("x_req_stable", {31'd0, tx_req}, {31'd0, exp_req});
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_ack   = 1'b0;

    // 1: reset and flush
    repeat (3) tick();
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_req", {31'd0, tx_req}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    chk("rst_to", {31'd0, timeout_err}, 0);
`endif
    rst = 1'b0;
    chk("flush0_ready", {31'd0, in_ready}, 0);
    tick();
    chk("flush1_ready", {31'd0, in_ready}, 0);
    chk("flush1_req", {31'd0, tx_req}, 0);
    tick();
    chk("idle_ready", {31'd0, in_ready}, 1);
    chk("idle_req", {31'd0, tx_req}, 0);
    chk("idle_data", {24'd0, tx_data}, 0);

    // 2: single transfer, ack 3 cycles after acceptance
    xfer(8'hA5, 3);
    in_valid = 1'b0;

    // 3: back-to-back with in_valid held high, ack after 4 cycles
    xfer(8'h11, 4);
    xfer(8'h22, 4);
    xfer(8'h33, 4);
    in_valid = 1'b0;
    chk("b2b_req_parity", {31'd0, tx_req}, 0);

    // 5: spurious ack toggle in IDLE is not acted on
    tx_ack = 1'b1;
    repeat (5) begin
      tick();
      chk("spur_ready", {31'd0, in_ready}, 1);
      chk("spur_busy", {31'd0, busy}, 0);
      chk("spur_data", {24'd0, tx_data}, 8'h33);
      chk("spur_req", {31'd0, tx_req}, 0);
    end
    // Next acceptance absorbs the mismatch: ack_sync already equals new req.
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    in_valid = 1'b0;
    exp_req  = 1'b1;
    chk("absorb_req", {31'd0, tx_req}, 1);
    chk("absorb_busy", {31'd0, busy}, 1);
    tick();
    chk("absorb_ready", {31'd0, in_ready}, 1);
    chk("absorb_data", {24'd0, tx_data}, 8'h44);

    // 4: reset in WAIT_ACK with tx_req=1
    xfer(8'h55, 2);
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_valid = 1'b0;
    chk("mid_req_pre", {31'd0, tx_req}, 1);
    chk("mid_busy_pre", {31'd0, busy}, 1);
    rst    = 1'b1;
    tx_ack = 1'b1;
    #1;
    chk("mid_req_async", {31'd0, tx_req}, 0);
    chk("mid_data_async", {24'd0, tx_data}, 0);
    chk("mid_busy_async", {31'd0, busy}, 0);
    chk("mid_ready_async", {31'd0, in_ready}, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("mid_flush_ready", {31'd0, in_ready}, 0);
    chk("mid_flush_req", {31'd0, tx_req}, 0);
    tick();
    chk("mid_realign_ready", {31'd0, in_ready}, 1);
    chk("mid_realign_req", {31'd0, tx_req}, 1);
    exp_req = 1'b1;
    xfer(8'h77, 2);
    in_valid = 1'b0;
    chk("mid_after_req", {31'd0, tx_req}, 0);

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    // 6: timeout with no ack
    in_valid = 1'b1;
    in_data  = 8'h88;
    tick();
    in_valid = 1'b0;
    chk("to_busy", {31'd0, busy}, 1);
    repeat (15) tick();
    chk("to_not_yet", {31'd0, timeout_err}, 0);
    tick();
    chk("to_set", {31'd0, timeout_err}, 1);
    repeat (5) tick();
    chk("to_sticky", {31'd0, timeout_err}, 1);
    chk("to_still_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("to_rst_clr", {31'd0, timeout_err}, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-domain half of a 2-phase (toggle) req/ack clock-domain-crossing handshake.
- Accepts a word on a valid/ready interface in its own clock.
- Holds the word stable on tx_data and toggles tx_req.
- Waits until the destination's tx_ack toggle, synchronized locally, matches tx_req before accepting the next word.
- Pairs with a destination-side receiver that synchronizes tx_req with the existing synchronizer block.

Parameters:
WIDTH, 8, data word width in bits
SYNC_STAGES, 2, flip-flop stages in the tx_ack synchronizer; legal range 2..4

Ports:
clk  input  1  source-domain clock
rst  input  1  reset; asynchronous assert, active-high
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  upstream word
tx_data  output  WIDTH  registered word presented to the destination domain
tx_req  output  1  request toggle; each transition announces a new tx_data
tx_ack  input  1  acknowledge toggle from the destination domain; asynchronous to clk
busy  output  1  high while a transfer is outstanding (state WAIT_ACK)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: tx_req=0, tx_data=0, busy=0, state=FLUSH, flush counter=0.
- in_ready is 0 whenever rst is high.
- ack_sync is tx_ack passed through SYNC_STAGES flip-flops (synchronizer sub-module, no reset).
- The FSM has three states: FLUSH, IDLE and WAIT_ACK.
- FLUSH:
  - in_ready=0.
  - Counts SYNC_STAGES cycles after reset release, so that stale synchronizer contents drain.
  - On the last count, tx_req is loaded with ack_sync (realigns parity if the destination was not reset). Next state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge N: tx_data<=in_data, tx_req<=~tx_req, next state WAIT_ACK.
  - New tx_req and tx_data are visible after edge N, both from the same edge. tx_data is never updated except on acceptance.
- WAIT_ACK:
  - in_ready=0, busy=1.
  - in_valid is ignored; upstream must hold its word.
  - Leave for IDLE on the first edge where ack_sync == tx_req.
- Latency: next acceptance is possible SYNC_STAGES+1 cycles after tx_ack toggles. The minimum accept-to-accept spacing is therefore destination round trip + SYNC_STAGES + 1 cycles.
- A tx_ack toggle while in IDLE (ack_sync != tx_req, spurious) is not acted on. The block stays in IDLE, and the mismatch is absorbed by the next acceptance only through normal toggle parity. The destination must never produce such a toggle.
- Reset mid-transfer: outputs return immediately to their reset values, then FLUSH realigns parity. The in-flight word is lost.
- in_ready depends only on state and rst. There is no combinational path from in_valid to in_ready.

Optional Feature:
Macro CDC_HANDSHAKE_TX_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output timeout_err (1 bit).
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err sets and stays set until rst.
  - The FSM does not abort; it keeps waiting for ack.
- Undefined: no counter, no port, no parameter; behaviour otherwise identical.

Decomposition:
- Shared package cdc_pkg holds:
  - the state enum typedef (FLUSH, IDLE, WAIT_ACK)
  - localparam MIN_SYNC_STAGES=2 and MAX_SYNC_STAGES=4, used for the parameter assertion
- One sub-module: instantiate the existing synchronizer for tx_ack, chained or parameterized to SYNC_STAGES. No other hierarchy.

Test Plan:
1. Reset then release: in_ready=0 for exactly 2 cycles (FLUSH), then 1; tx_req=0 and tx_data=0 throughout.
2. Single transfer: in_data=8'hA5 accepted at edge N; tx_data=A5 and tx_req=1 after edge N. Bench toggles tx_ack 3 cycles later; in_ready returns to 1 exactly 3 cycles (2 sync + 1) after the tx_ack change.
3. Back-to-back: in_valid held high with words 11, 22, 33 and the bench acks each after 4 cycles. Each word appears on tx_data exactly once, in order; tx_req toggles 3 times; no word is accepted while busy=1.
4. Reset mid-transfer: assert rst while in WAIT_ACK with tx_req=1. tx_req=0, tx_data=0 and busy=0 immediately (asynchronous). With tx_ack held at 1, tx_req=1 after FLUSH and the next transfer toggles it to 0.
5. Spurious ack in IDLE: toggle tx_ack with no transfer pending. State remains IDLE and tx_data is unchanged.
6. With CDC_HANDSHAKE_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16: accept a word and never ack. timeout_err rises 16 cycles after entering WAIT_ACK, busy stays 1, and timeout_err clears only on rst.
